muxn21_arb: RTL

//  N-way, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.

---
 rtl/muxn21_arb_pkg.sv | 37 +++
 rtl/muxn21_arb_if.sv | 29 ++
 rtl/muxn21_arb_rr_arbiter.sv | 27 ++
 rtl/muxn21_arb.sv | 101 ++++++++++
 4 files changed

// File: rtl/muxn21_arb_pkg.sv
// Shared definitions for the MCU data-path multiplexers: arbitration mode
// encoding and a round-robin search usable by any arbiter up to 16 requesters.
package mcu_mux_pkg;

    typedef enum logic {MUX_FIXED = 1'b0, MUX_RR = 1'b1} mux_mode_t;

    localparam int unsigned RR_MAX_N = 16;
    localparam int unsigned RR_IDX_W = 4;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
    } rr_grant_t;

    // First requester strictly after ptr, wrapping at n; ptr itself is checked last.
    function automatic rr_grant_t rr_next(input logic [RR_MAX_N-1:0] req,
                                          input logic [RR_IDX_W-1:0] ptr,
                                          input int unsigned        n);
        rr_grant_t        g;
        logic [RR_IDX_W:0] cand;
        g = '0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n) begin
                cand = {1'b0, ptr} + (RR_IDX_W + 1)'(k);
                if (cand >= (RR_IDX_W + 1)'(n)) begin
                    cand = cand - (RR_IDX_W + 1)'(n);
                end
                if (!g.valid && req[cand[RR_IDX_W-1:0]]) begin
                    g.valid = 1'b1;
                    g.idx   = cand[RR_IDX_W-1:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/muxn21_arb_if.sv
// Producer/consumer handshake bundle for muxn21_arb; the block itself uses
// the slave modport, the driving environment the master modport.
interface muxn21_arb_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic [N*WIDTH-1:0] IN_DATA;
    logic [N-1:0]       IN_VALID;
    logic [N-1:0]       IN_READY;
    logic               MODE;
    logic [SELW-1:0]    SEL;
    logic [WIDTH-1:0]   OUT_DATA;
    logic [SELW-1:0]    OUT_SRC;
    logic               OUT_VALID;
    logic               OUT_READY;

    modport master (
        output IN_DATA, IN_VALID, MODE, SEL, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_SRC, OUT_VALID
    );

    modport slave (
        input  IN_DATA, IN_VALID, MODE, SEL, OUT_READY,
        output IN_READY, OUT_DATA, OUT_SRC, OUT_VALID
    );

endinterface

// File: rtl/muxn21_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr.
module rr_arbiter
    import mcu_mux_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [RR_MAX_N-1:0] req_ext;
    logic [RR_IDX_W-1:0] ptr_ext;
    rr_grant_t           g;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        ptr_ext        = RR_IDX_W'(ptr);
        g              = rr_next(req_ext, ptr_ext, N);
        grant_valid    = g.valid;
        grant_idx      = SELW'(g.idx);
    end

endmodule

// File: rtl/muxn21_arb.sv
// N-way registered multiplexer with valid/ready handshakes, fixed-select or
// round-robin arbitration, and a 1-entry full-throughput output register.
module muxn21_arb
    import mcu_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RST,
    muxn21_arb_if.slave  bus
);

    localparam int unsigned NPAD = 1 << SELW;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q,  out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,      ptr_d;

    mux_mode_t        mode;
    logic [NPAD-1:0]  valid_pad;
    logic [SELW-1:0]  rr_idx;
    logic             rr_valid;
    logic [SELW-1:0]  grant_idx;
    logic             grant_valid;
    logic             load_ok;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
    logic [N-1:0]     in_ready;

    assign mode = mux_mode_t'(bus.MODE);

    rr_arbiter #(.N(N)) u_rr (
        .req         (bus.IN_VALID),
        .ptr         (ptr_q),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    // Padding to a power of two makes an out-of-range SEL read a zero valid.
    always_comb begin
        valid_pad        = '0;
        valid_pad[N-1:0] = bus.IN_VALID;
        if (mode == MUX_RR) begin
            grant_idx   = rr_idx;
            grant_valid = rr_valid;
        end else begin
            grant_idx   = bus.SEL;
            grant_valid = valid_pad[bus.SEL];
        end
        load_ok    = ~out_valid_q | bus.OUT_READY;
        xfer       = grant_valid & load_ok & ~RST;
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = xfer;
                grant_data  = bus.IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MUX_RR) begin
                ptr_d = grant_idx;
            end
        end else if (bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SRC   = out_src_q;
    assign bus.OUT_VALID = out_valid_q;

endmodule
